// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives probe to a registered comparator's b operand
// and binary-searches the comparator's a operand MSB first, stopping early on an equal result.
module sar_search_ctrl #(
   parameter int WIDTH   = 8,
   parameter int CMP_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_equal,
   input  logic             cmp_greater,
   input  logic             cmp_less,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             exact,
   output logic             error
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n, acc_upd;
   logic [IW-1:0]    idx, idx_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] probe_n, result_n;
   logic             busy_n, done_n, exact_n, error_n;
   logic             cmp_onehot;

   // Exactly one comparator flag must be set for a result to be trusted.
   always_comb begin
      case ({cmp_equal, cmp_greater, cmp_less})
         3'b100, 3'b010, 3'b001: cmp_onehot = 1'b1;
         default:                cmp_onehot = 1'b0;
      endcase
   end

   assign acc_upd = cmp_greater ? probe : acc;

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      idx_n    = idx;
      cnt_n    = cnt;
      probe_n  = probe;
      result_n = result;
      busy_n   = busy;
      done_n   = 1'b0;
      exact_n  = exact;
      error_n  = error;
      case (state)
         IDLE: begin
            if (start) begin
               acc_n   = '0;
               idx_n   = IW'(WIDTH - 1);
               probe_n = WIDTH'(1) << (WIDTH - 1);
               busy_n  = 1'b1;
               exact_n = 1'b0;
               error_n = 1'b0;
               cnt_n   = CW'(CMP_LAT);
               state_n = WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) state_n = EVAL;
         end
         EVAL: begin
            if (!cmp_onehot) begin
               error_n  = 1'b1;
               result_n = acc;
               exact_n  = 1'b0;
               done_n   = 1'b1;
               busy_n   = 1'b0;
               state_n  = IDLE;
            end else if (cmp_equal) begin
               result_n = probe;
               exact_n  = 1'b1;
               done_n   = 1'b1;
               busy_n   = 1'b0;
               state_n  = IDLE;
            end else if (idx != '0) begin
               acc_n   = acc_upd;
               idx_n   = idx - IW'(1);
               probe_n = acc_upd | (WIDTH'(1) << (idx - IW'(1)));
               cnt_n   = CW'(CMP_LAT);
               state_n = WAIT;
            end else begin
               // Last bit decided without an equal hit: the accumulator is the answer.
               acc_n    = acc_upd;
               result_n = acc_upd;
               exact_n  = 1'b0;
               done_n   = 1'b1;
               busy_n   = 1'b0;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         idx    <= IW'(WIDTH - 1);
         cnt    <= '0;
         probe  <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         exact  <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         probe  <= probe_n;
         result <= result_n;
         busy   <= busy_n;
         done   <= done_n;
         exact  <= exact_n;
         error  <= error_n;
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a registered comparator model answers probes, and a plain
// binary-search reference predicts the probe sequence, done timing and final result.
module tb_sar_search_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cmp_equal, cmp_greater, cmp_less;
   logic [7:0] probe, result;
   logic       busy, done, exact, error;

   logic [7:0] a_val;
   logic       force_bad;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sar_search_ctrl #(.WIDTH(8), .CMP_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_less(cmp_less),
      .probe(probe), .busy(busy), .done(done), .result(result),
      .exact(exact), .error(error)
   );

   // One-stage registered comparator a-vs-probe, with a fault injector.
   always @(posedge clk) begin
      if (force_bad) begin
         cmp_equal <= 1'b0; cmp_greater <= 1'b1; cmp_less <= 1'b1;
      end else begin
         cmp_equal   <= (a_val == probe);
         cmp_greater <= (a_val >  probe);
         cmp_less    <= (a_val <  probe);
      end
   end

   // Reference: ordinary bitwise binary search over the value range.
   task automatic model(input logic [7:0] a, output logic [7:0] pr[8], output int k,
                        output logic [7:0] res, output logic ex);
      logic [7:0] lo, cand;
      lo = 0; k = 0; ex = 0; res = 0;
      for (int i = 7; i >= 0; i--) begin
         cand = lo + 8'(1 << i);
         pr[k] = cand; k++;
         if (a == cand) begin ex = 1; res = cand; return; end
         if (a > cand) lo = cand;
      end
      res = lo;
   endtask

   // Caller leaves start low; this raises it, runs the search and checks every cycle.
   task automatic run_search(input logic [7:0] a, input bit keep_start);
      logic [7:0] pr[8];
      int k;
      logic [7:0] res;
      logic ex;
      model(a, pr, k, res, ex);
      a_val = a;
      start = 1'b1;
      @(posedge clk); #1;
      if (!keep_start) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || probe !== pr[0] || error !== 1'b0) begin
         errors++;
         $display("FAIL start a=%h: busy=%b done=%b probe=%h error=%b, need busy=1 done=0 probe=%h error=0",
                  a, busy, done, probe, error, pr[0]);
      end
      for (int j = 1; j <= 2 * k; j++) begin
         @(posedge clk); #1;
         checks++;
         if (j < 2 * k) begin
            if (done !== 1'b0 || busy !== 1'b1 || probe !== pr[j / 2]) begin
               errors++;
               $display("FAIL step a=%h cyc=%0d: done=%b busy=%b probe=%h, need done=0 busy=1 probe=%h",
                        a, j, done, busy, probe, pr[j / 2]);
            end
         end else if (done !== 1'b1 || busy !== 1'b0 || result !== res || exact !== ex || error !== 1'b0) begin
            errors++;
            $display("FAIL finish a=%h cyc=%0d: done=%b busy=%b result=%h exact=%b error=%b, need 1 0 %h %b 0",
                     a, j, done, busy, result, exact, error, res, ex);
         end
      end
   endtask

   task automatic check_done_drops();
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b, need 0 0", done, busy);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (probe !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 ||
          exact !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL %s: probe=%h busy=%b done=%b result=%h exact=%b error=%b, need all zero",
                  tag, probe, busy, done, result, exact, error);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; force_bad = 1'b0; a_val = 8'h00;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_search(8'hA5, 0); check_done_drops();
      run_search(8'h80, 0); check_done_drops();
      run_search(8'h00, 0); check_done_drops();
      run_search(8'h01, 0); check_done_drops();
      run_search(8'h7F, 0); check_done_drops();
   endtask

   // start held through a whole search must not restart it; it is taken right after done.
   task automatic test_back_to_back();
      run_search(8'hFF, 1);
      run_search(8'h5A, 0);
      check_done_drops();
   endtask

   task automatic test_error();
      a_val = 8'h42; force_bad = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL err_wait: done=%b busy=%b, need 0 1", done, busy);
      end
      @(posedge clk); #1;
      force_bad = 1'b0;
      checks++;
      if (done !== 1'b1 || error !== 1'b1 || result !== 8'h00 || exact !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_end: done=%b error=%b result=%h exact=%b busy=%b, need 1 1 00 0 0",
                  done, error, result, exact, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (error !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL err_hold: error=%b done=%b, need 1 0", error, done);
      end
      run_search(8'h42, 0);   // its start-edge check also requires error cleared
      check_done_drops();
   endtask

   task automatic test_reset_mid_search();
      a_val = 8'h3C; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_vals("mid_reset");
      @(posedge clk); #1;
      check_reset_vals("mid_reset_hold");
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: done=%b busy=%b, need 0 0", done, busy);
         end
      end
      run_search(8'h3C, 0);
      check_done_drops();
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_search(8'($urandom_range(0, 255)), 0);
         repeat ($urandom_range(0, 3)) check_done_drops();
      end
   endtask

   initial begin
      cmp_equal = 0; cmp_greater = 0; cmp_less = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_error();
      test_reset_mid_search();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
